// File: rtl/lfsr_rng_arbiter.sv
// ---------------------------------------------------------------------------
// lfsr_rng_arbiter
//   Shares one 32-bit Fibonacci LFSR among N_REQ requesters. A round-robin
//   arbiter picks a requester. The LFSR is then stepped WORD_W times to build
//   a random word. The word is returned together with a one-cycle grant
//   pulse. Seeds can be loaded while the block is idle.
//
// Ports
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous, active-high reset
//   seed_load in   1       load seed_val into the LFSR (honoured in IDLE only)
//   seed_val  in   32      new seed; an all-zero value is replaced by SEED
//   req       in   N_REQ   level requests, held until granted
//   gnt       out  N_REQ   one-hot, one-cycle pulse marking rnd_word valid
//   rnd_word  out  WORD_W  last delivered word, registered
//   busy      out  1       high while filling or delivering a word
// ---------------------------------------------------------------------------
module lfsr_rng_arbiter #(
  parameter int          N_REQ  = 4,
  parameter int          WORD_W = 16,
  parameter logic [31:0] SEED   = 32'h974CA351
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [31:0]       seed_val,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [WORD_W-1:0] rnd_word,
  output logic              busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(WORD_W);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;

  // Feedback bit of the x^32+x^31+x^30+x^28+x^26+1 style tap set (bits 31,30,29,27,25,0).
  function automatic logic lfsr_fb(input logic [31:0] s);
    return s[31] ^ s[30] ^ s[29] ^ s[27] ^ s[25] ^ s[0];
  endfunction

  // Requester index k positions after base, wrapping at N_REQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % N_REQ);
  endfunction

  logic [1:0]        state_r;
  logic [31:0]       lfsr_r;
  logic [WORD_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  win_r;
  logic [IDX_W-1:0]  last_r;
  logic [N_REQ-1:0]  gnt_r;
  logic [WORD_W-1:0] rnd_word_r;
  logic              busy_r;

  logic              fb_s;
  logic [IDX_W-1:0]  pick_s;

  // Next LFSR bit from the current state.
  always_comb begin
    fb_s = lfsr_fb(lfsr_r);
  end

  // Round-robin pick: scan from the farthest position back to last+1 so the
  // nearest active requester after the previous winner overwrites the rest.
  always_comb begin
    pick_s = last_r;
    for (int k = N_REQ; k >= 1; k--) begin
      pick_s = req[rr_idx(last_r, k)] ? rr_idx(last_r, k) : pick_s;
    end
  end

  // Control FSM, LFSR, word accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lfsr_r     <= SEED;
      acc_r      <= {WORD_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      win_r      <= {IDX_W{1'b0}};
      last_r     <= IDX_W'(N_REQ - 1);
      gnt_r      <= {N_REQ{1'b0}};
      rnd_word_r <= {WORD_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      gnt_r <= {N_REQ{1'b0}};
      case (state_r)
        ST_IDLE: begin
          // A seed load takes this cycle; any pending request waits one cycle.
          if (seed_load) begin
            lfsr_r <= (seed_val == 32'h0000_0000) ? SEED : seed_val;
          end else if (|req) begin
            win_r   <= pick_s;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_FILL;
            busy_r  <= 1'b1;
          end
        end
        ST_FILL: begin
          // First bit produced ends up in the MSB after WORD_W shifts.
          lfsr_r <= {fb_s, lfsr_r[31:1]};
          acc_r  <= {acc_r[WORD_W-2:0], fb_s};
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(WORD_W - 1)) begin
            state_r <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          // A withdrawn request forfeits the word; arbitration still advances.
          if (req[win_r]) begin
            gnt_r      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_r;
            rnd_word_r <= acc_r;
          end
          last_r  <= win_r;
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_r;
  assign rnd_word = rnd_word_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lfsr_rng_arbiter
//   Directed bench for lfsr_rng_arbiter (N_REQ=4, WORD_W=16, default SEED).
//   Expected words come from an independent mask/parity LFSR model; grant
//   order and latencies are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_lfsr_rng_arbiter;

  localparam logic [31:0] SEED = 32'h974CA351;

  logic        clk;
  logic        rst;
  logic        seed_load;
  logic [31:0] seed_val;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [15:0] rnd_word;
  logic        busy;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          fail_cnt  = 0;

  logic [31:0] m_s;
  logic [15:0] w_exp;
  logic [15:0] w_t1;
  logic [15:0] w_prev;
  logic [3:0]  g_exp;
  int          cyc;
  int          bcyc;
  int          seen_gnt;

  lfsr_rng_arbiter #(.N_REQ(4), .WORD_W(16), .SEED(SEED)) dut (
    .clk      (clk),
    .rst      (rst),
    .seed_load(seed_load),
    .seed_val (seed_val),
    .req      (req),
    .gnt      (gnt),
    .rnd_word (rnd_word),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for any grant; reports edges seen and edges with busy high.
  task automatic wait_gnt(input int max_cyc, output int c, output int b);
    c = 0;
    b = 0;
    do begin
      tick();
      c++;
      if (busy) b++;
    end while (gnt == 4'b0000 && c < max_cyc);
  endtask

  // Reference LFSR: feedback is the parity of the tapped bits (mask 0xEA000001).
  task automatic model_word(output logic [15:0] w);
    logic b;
    w = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      b   = ^(m_s & 32'hEA00_0001);
      w   = {w[14:0], b};
      m_s = {b, m_s[31:1]};
    end
  endtask

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed_val = 32'h0; req = 4'b0000;
    m_s = SEED;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt",  {28'h0, gnt}, 32'h0);
    chk("reset_word", {16'h0, rnd_word}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_lfsr", dut.lfsr_r, SEED);
    rst = 1'b0;
    tick();

    // Test 1: single requester 0 from reset
    req = 4'b0001;
    wait_gnt(40, cyc, bcyc);
    model_word(w_exp);
    w_t1 = w_exp;
    chk("t1_gnt",      {28'h0, gnt}, 32'h1);
    chk("t1_latency",  cyc, 32'd18);
    chk("t1_busy_len", bcyc, 32'd17);
    chk("t1_msb",      {31'h0, rnd_word[15]}, 32'h1);
    chk("t1_word",     {16'h0, rnd_word}, {16'h0, w_exp});
    req = 4'b0000;
    tick();
    chk("t1_pulse",    {28'h0, gnt}, 32'h0);
    chk("t1_word_hold", {16'h0, rnd_word}, {16'h0, w_exp});

    // Test 2: all requesters, round robin from a fresh reset
    rst = 1'b1; #1; rst = 1'b0;
    m_s = SEED;
    tick();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(40, cyc, bcyc);
      model_word(w_exp);
      g_exp = 4'b0001 << (i % 4);
      chk("t2_gnt",    {28'h0, gnt}, {28'h0, g_exp});
      chk("t2_period", cyc, 32'd18);
      chk("t2_word",   {16'h0, rnd_word}, {16'h0, w_exp});
    end
    req = 4'b0000;
    tick();
    tick();

    // Test 3: zero seed falls back to SEED
    seed_load = 1'b1; seed_val = 32'h0;
    tick();
    seed_load = 1'b0;
    m_s = SEED;
    req = 4'b0100;
    wait_gnt(40, cyc, bcyc);
    model_word(w_exp);
    chk("t3_gnt",     {28'h0, gnt}, 32'h4);
    chk("t3_latency", cyc, 32'd18);
    chk("t3_word",    {16'h0, rnd_word}, {16'h0, w_exp});
    chk("t3_eq_t1",   {16'h0, rnd_word}, {16'h0, w_t1});
    req = 4'b0000;
    tick();

    // Test 4a: seed_load beats a same-cycle request
    seed_load = 1'b1; seed_val = 32'h1234_5678; req = 4'b0010;
    tick();
    seed_load = 1'b0;
    chk("t4_idle",   {31'h0, busy}, 32'h0);
    chk("t4_loaded", dut.lfsr_r, 32'h1234_5678);
    m_s = 32'h1234_5678;
    wait_gnt(40, cyc, bcyc);
    model_word(w_exp);
    chk("t4_gnt",     {28'h0, gnt}, 32'h2);
    chk("t4_latency", cyc, 32'd18);
    chk("t4_word",    {16'h0, rnd_word}, {16'h0, w_exp});
    req = 4'b0000;
    tick();

    // Test 4b: seed_load during FILL is ignored
    req = 4'b1000;
    repeat (8) tick();
    seed_load = 1'b1; seed_val = 32'hDEAD_BEEF;
    tick();
    seed_load = 1'b0;
    wait_gnt(40, cyc, bcyc);
    model_word(w_exp);
    chk("t4b_gnt",     {28'h0, gnt}, 32'h8);
    chk("t4b_latency", cyc, 32'd9);
    chk("t4b_word",    {16'h0, rnd_word}, {16'h0, w_exp});
    w_prev = w_exp;
    req = 4'b0000;
    tick();

    // Test 5: winner withdraws during FILL
    req = 4'b0011;
    seen_gnt = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (gnt != 4'b0000) seen_gnt++;
      if (i == 4) req = 4'b0010;
    end
    chk("t5_no_gnt", seen_gnt, 32'd0);
    chk("t5_word_kept", {16'h0, rnd_word}, {16'h0, w_prev});
    model_word(w_exp);
    model_word(w_exp);
    wait_gnt(40, cyc, bcyc);
    chk("t5_gnt",     {28'h0, gnt}, 32'h2);
    chk("t5_latency", cyc, 32'd18);
    chk("t5_word",    {16'h0, rnd_word}, {16'h0, w_exp});
    req = 4'b0000;
    tick();

    // Test 6: reset in the middle of FILL
    req = 4'b0001;
    repeat (9) tick();
    chk("t6_busy_pre", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_gnt",  {28'h0, gnt}, 32'h0);
    chk("t6_word", {16'h0, rnd_word}, 32'h0);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_lfsr", dut.lfsr_r, SEED);
    req = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    req = 4'b0001;
    wait_gnt(40, cyc, bcyc);
    chk("t6_gnt_after", {28'h0, gnt}, 32'h1);
    chk("t6_latency",   cyc, 32'd18);
    chk("t6_word_t1",   {16'h0, rnd_word}, {16'h0, w_t1});
    req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
